round_window_multi: RTL and testbench

Parametrised multi-lane sliding-window word extractor for the sparse/dense polynomial multiplier datapath. It accepts a stream of dense-polynomial words, keeps the most recent DEPTH words in a circular buffer, and emits one adjacent word pair (left/right) per lane per produced output. Each lane reads at its own runtime offset, with zero padding before the first word and after the last word. It generalises the fixed two-tap (high/low) round block to NUM_LANES taps, arbitrary depth, ready/valid flow control on both sides, and an explicit done/drain protocol.

---
 rtl/round_window_multi_if.sv | 29 ++
 rtl/round_window_multi.sv | 167 ++++++++++++++++
 tb/tb_round_window_multi.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/round_window_multi_if.sv
// Word-stream input / lane-pair output handshake bundle for round_window_multi.
interface round_window_multi_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned OFF_WIDTH  = 6
);
    logic                            start;
    logic [NUM_LANES*OFF_WIDTH-1:0]  lane_off;
    logic                            in_valid;
    logic                            in_ready;
    logic [WORD_WIDTH-1:0]           in_word;
    logic                            in_only_add;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_LANES*WORD_WIDTH-1:0] out_left;
    logic [NUM_LANES*WORD_WIDTH-1:0] out_right;
    logic                            done;
    logic                            cfg_err;

    modport master (
        output start, lane_off, in_valid, in_word, in_only_add, out_ready,
        input  in_ready, out_valid, out_left, out_right, done, cfg_err
    );

    modport slave (
        input  start, lane_off, in_valid, in_word, in_only_add, out_ready,
        output in_ready, out_valid, out_left, out_right, done, cfg_err
    );
endinterface

// File: rtl/round_window_multi.sv
// Multi-lane sliding-window word extractor: circular buffer of the last DEPTH
// stream words, one adjacent (j, j-1) pair per lane per producing accept.
module round_window_multi #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned NUM_LANES  = 2,
    parameter int unsigned OFF_WIDTH  = 6,
    parameter int unsigned WORD_COUNT = 553
) (
    input  logic                clk,
    input  logic                rst_n,
    round_window_multi_if.slave bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = $clog2(WORD_COUNT + DEPTH + 1);
    localparam int unsigned MAX_OFF = DEPTH - 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [CW-1:0]                   r_n;
    logic [CW-1:0]                   r_last_n;
    logic [AW-1:0]                   r_wptr;
    logic [AW-1:0]                   r_off [NUM_LANES];
    logic [WORD_WIDTH-1:0]           r_buf [DEPTH];
    logic                            r_out_valid;
    logic                            r_done;
    logic                            r_cfg_err;
    logic [NUM_LANES*WORD_WIDTH-1:0] r_out_left;
    logic [NUM_LANES*WORD_WIDTH-1:0] r_out_right;

    logic                            w_in_ready;
    logic                            w_acc;
    logic                            w_prod;
    logic                            w_final;
    logic [WORD_WIDTH-1:0]           w_wdata;
    logic [AW-1:0]                   w_off_clamp [NUM_LANES];
    logic [AW-1:0]                   w_max_off;
    logic                            w_cfg_err;
    logic [AW-1:0]                   w_laddr [NUM_LANES];
    logic [AW-1:0]                   w_raddr [NUM_LANES];
    logic [CW-1:0]                   w_j [NUM_LANES];
    logic [NUM_LANES*WORD_WIDTH-1:0] w_left;
    logic [NUM_LANES*WORD_WIDTH-1:0] w_right;

    // Handshake qualifiers; start wins over a coincident accept.
    assign w_in_ready = (r_state == S_RUN) && (!r_out_valid || bus.out_ready);
    assign w_acc      = bus.in_valid && w_in_ready && !bus.start;
    assign w_prod     = w_acc && !bus.in_only_add;
    // Final when n' reaches WORD_COUNT+max_off+1, i.e. n (pre-increment) >= r_last_n.
    assign w_final    = w_prod && (r_n >= r_last_n);
    // Stream positions past the polynomial are stored as zero.
    assign w_wdata    = (r_n < CW'(WORD_COUNT)) ? bus.in_word : '0;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_left  = r_out_left;
    assign bus.out_right = r_out_right;
    assign bus.done      = r_done;
    assign bus.cfg_err   = r_cfg_err;

    // Clamp incoming lane offsets and find the largest, for sampling at start.
    always_comb begin
        w_cfg_err = 1'b0;
        w_max_off = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            w_off_clamp[k] = AW'(bus.lane_off[k*OFF_WIDTH +: OFF_WIDTH]);
            if (32'(bus.lane_off[k*OFF_WIDTH +: OFF_WIDTH]) > MAX_OFF) begin
                w_off_clamp[k] = AW'(MAX_OFF);
                w_cfg_err      = 1'b1;
            end
            if (w_off_clamp[k] > w_max_off) begin
                w_max_off = w_off_clamp[k];
            end
        end
    end

    // Per-lane pair read; j = n - off, left gated to 0<=j<WORD_COUNT, right to j-1.
    always_comb begin
        w_left  = '0;
        w_right = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            w_laddr[k] = r_wptr - r_off[k];
            w_raddr[k] = r_wptr - r_off[k] - AW'(1);
            w_j[k]     = r_n - CW'(r_off[k]);
            if ((r_n >= CW'(r_off[k])) && (w_j[k] < CW'(WORD_COUNT))) begin
                // Offset 0 reads the word being written this cycle.
                w_left[k*WORD_WIDTH +: WORD_WIDTH] =
                    (r_off[k] == '0) ? w_wdata : r_buf[w_laddr[k]];
            end
            if ((r_n > CW'(r_off[k])) && ((w_j[k] - CW'(1)) < CW'(WORD_COUNT))) begin
                w_right[k*WORD_WIDTH +: WORD_WIDTH] = r_buf[w_raddr[k]];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start restarts from any state, final accept ends the run.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.start) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (w_final) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Counters, sampled configuration and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n         <= '0;
            r_last_n    <= '0;
            r_wptr      <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_out_left  <= '0;
            r_out_right <= '0;
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                r_off[k] <= '0;
            end
        end else if (bus.start) begin
            r_n         <= '0;
            r_wptr      <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_err   <= w_cfg_err;
            r_last_n    <= CW'(WORD_COUNT) + CW'(w_max_off);
            for (int unsigned k = 0; k < NUM_LANES; k++) begin
                r_off[k] <= w_off_clamp[k];
            end
        end else begin
            r_done <= w_final;
            if (w_acc) begin
                r_n    <= r_n + CW'(1);
                r_wptr <= r_wptr + AW'(1);
            end
            // Only-add accepts leave the pair registers alone; a held pair still drains.
            if (w_prod) begin
                r_out_valid <= 1'b1;
                r_out_left  <= w_left;
                r_out_right <= w_right;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Circular word buffer; contents are never cleared, reads are gated by n.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_buf[r_wptr] <= w_wdata;
        end
    end
endmodule

// File: tb/tb_round_window_multi.sv
// Self-checking bench for round_window_multi: two configurations, reference model
// computed directly from stream indices and lane offsets.
module tb_round_window_multi;
    localparam int unsigned WW = 32;
    localparam int unsigned NL = 2;
    localparam int unsigned OW = 4;
    localparam int unsigned LW = NL * WW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_only_add = 1'b0;
    logic          out_ready = 1'b1;
    logic [NL*OW-1:0] lane_off = '0;
    logic [WW-1:0] in_word = '0;
    int            sel = 0;

    always #5 clk = ~clk;

    round_window_multi_if #(.WORD_WIDTH(WW), .NUM_LANES(NL), .OFF_WIDTH(OW)) bus_a ();
    round_window_multi_if #(.WORD_WIDTH(WW), .NUM_LANES(NL), .OFF_WIDTH(OW)) bus_b ();

    assign bus_a.start       = start && (sel == 0);
    assign bus_a.lane_off    = lane_off;
    assign bus_a.in_valid    = in_valid && (sel == 0);
    assign bus_a.in_word     = in_word;
    assign bus_a.in_only_add = in_only_add;
    assign bus_a.out_ready   = out_ready;
    assign bus_b.start       = start && (sel == 1);
    assign bus_b.lane_off    = lane_off;
    assign bus_b.in_valid    = in_valid && (sel == 1);
    assign bus_b.in_word     = in_word;
    assign bus_b.in_only_add = in_only_add;
    assign bus_b.out_ready   = out_ready;

    round_window_multi #(.WORD_WIDTH(WW), .DEPTH(8), .NUM_LANES(NL), .OFF_WIDTH(OW),
                         .WORD_COUNT(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
    round_window_multi #(.WORD_WIDTH(WW), .DEPTH(4), .NUM_LANES(NL), .OFF_WIDTH(OW),
                         .WORD_COUNT(10)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

    logic          o_in_ready, o_valid, o_done, o_cfg_err;
    logic [LW-1:0] o_left, o_right;
    assign o_in_ready = (sel == 0) ? bus_a.in_ready  : bus_b.in_ready;
    assign o_valid    = (sel == 0) ? bus_a.out_valid : bus_b.out_valid;
    assign o_done     = (sel == 0) ? bus_a.done      : bus_b.done;
    assign o_cfg_err  = (sel == 0) ? bus_a.cfg_err   : bus_b.cfg_err;
    assign o_left     = (sel == 0) ? bus_a.out_left  : bus_b.out_left;
    assign o_right    = (sel == 0) ? bus_a.out_right : bus_b.out_right;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WW-1:0] st_word [64];
    bit            st_oadd [64];
    int            st_len;
    logic [LW-1:0] exp_l[$], exp_r[$], got_l[$], got_r[$];
    int            exp_acc, got_acc, done_cycles, done_idx, hold_viol;
    bit            exp_err, timed_out;

    // Reference: every producing accept at stream index i emits, per lane,
    // (word[i-off], word[i-off-1]) with out-of-polynomial positions as zero.
    task automatic build_model(input int depth, input int wc, input int off0, input int off1);
        int offc [NL];
        int maxo, fin, j;
        logic [LW-1:0] pl, pr;
        offc[0] = (off0 > depth - 2) ? depth - 2 : off0;
        offc[1] = (off1 > depth - 2) ? depth - 2 : off1;
        exp_err = (off0 > depth - 2) || (off1 > depth - 2);
        maxo = (offc[0] > offc[1]) ? offc[0] : offc[1];
        fin  = wc + maxo + 1;
        exp_l.delete();
        exp_r.delete();
        exp_acc = -1;
        for (int i = 0; i < st_len; i++) begin
            if (!st_oadd[i]) begin
                for (int k = 0; k < NL; k++) begin
                    j = i - offc[k];
                    pl[k*WW +: WW] = '0;
                    pr[k*WW +: WW] = '0;
                    if (j >= 0 && j < wc) pl[k*WW +: WW] = st_word[j];
                    if (j - 1 >= 0 && j - 1 < wc) pr[k*WW +: WW] = st_word[j-1];
                end
                exp_l.push_back(pl);
                exp_r.push_back(pr);
                if (i + 1 >= fin) begin
                    exp_acc = i + 1;
                    break;
                end
            end
        end
    endtask

    task automatic fill_basic();
        st_len = 16;
        for (int i = 0; i < 64; i++) begin
            st_word[i] = $urandom;
            st_oadd[i] = 1'b0;
        end
        st_word[0] = 32'h11;
        st_word[1] = 32'h22;
        st_word[2] = 32'h33;
        st_word[3] = 32'h44;
    endtask

    task automatic do_start(input int s, input int off0, input int off1);
        logic [OW-1:0] a, b;
        a = OW'(off0);
        b = OW'(off1);
        sel = s;
        lane_off = {b, a};
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Drives the stream and records every output handshake; no comparisons here.
    // mode 0: always ready, 1: 5-cycle stall after the first output, 2: random ready.
    task automatic run_stream(input int mode, input int max_cycles);
        int idx, cyc, first_seen;
        bit prev_hold;
        logic [LW-1:0] hl, hr;
        idx = 0; cyc = 0; first_seen = -1; prev_hold = 0; hl = '0; hr = '0;
        got_l.delete(); got_r.delete();
        done_cycles = 0; done_idx = -1; hold_viol = 0; timed_out = 0;
        while (!(done_cycles > 0 && !o_valid)) begin
            if (cyc >= max_cycles) begin
                timed_out = 1;
                break;
            end
            case (mode)
                1:       out_ready = !(first_seen >= 0 && cyc > first_seen && cyc <= first_seen + 5);
                2:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b1;
            endcase
            in_valid = (idx < st_len);
            in_word = $urandom;
            in_only_add = 1'b0;
            if (idx < st_len) begin
                in_word = st_word[idx];
                in_only_add = st_oadd[idx];
            end
            #1;
            if (prev_hold && (!o_valid || o_left !== hl || o_right !== hr)) hold_viol++;
            if (o_valid && !out_ready && o_in_ready) hold_viol++;
            if (o_done) begin
                done_cycles++;
                if (done_idx < 0) done_idx = got_l.size();
            end
            if (o_valid && first_seen < 0) first_seen = cyc;
            prev_hold = o_valid && !out_ready;
            hl = o_left;
            hr = o_right;
            if (o_valid && out_ready) begin
                got_l.push_back(o_left);
                got_r.push_back(o_right);
            end
            if (in_valid && o_in_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_only_add = 1'b0;
        out_ready = 1'b1;
        got_acc = idx;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            n_tests++;
            if ({o_in_ready, o_valid, o_done, o_cfg_err} !== 4'b0000 || o_left !== '0 || o_right !== '0) begin
                n_fail++;
                $display("FAIL reset dut%0d: rdy/val/done/err=%b left=%h right=%h, want all zero",
                         s, {o_in_ready, o_valid, o_done, o_cfg_err}, o_left, o_right);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (o_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: in_ready=%b want 0", o_in_ready);
        end
    endtask

    task automatic test_basic();
        logic [LW-1:0] t;
        fill_basic();
        build_model(8, 4, 0, 2);
        do_start(0, 0, 2);
        run_stream(0, 200);
        n_tests++;
        if (timed_out || got_l.size() != 7 || exp_l.size() != 7) begin
            n_fail++;
            $display("FAIL basic_count: got %0d outputs (timeout=%0d), want 7", got_l.size(), timed_out);
        end
        for (int i = 0; i < exp_l.size(); i++) begin
            n_tests++;
            if (i >= got_l.size() || got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                n_fail++;
                $display("FAIL basic_out%0d: got %h/%h want %h/%h", i,
                         (i < got_l.size()) ? got_l[i] : 'x, (i < got_r.size()) ? got_r[i] : 'x, exp_l[i], exp_r[i]);
            end
        end
        if (got_l.size() > 3) begin
            t = got_l[2];
            n_tests++;
            if (t[2*WW-1:WW] !== 32'h11) begin
                n_fail++;
                $display("FAIL basic_lane1_out3: left=%h want 11", t[2*WW-1:WW]);
            end
        end
        n_tests++;
        if (done_cycles != 1 || done_idx != 6 || got_acc != exp_acc) begin
            n_fail++;
            $display("FAIL basic_done: pulses=%0d at_out=%0d acc=%0d want 1/6/%0d",
                     done_cycles, done_idx, got_acc, exp_acc);
        end
    endtask

    task automatic test_only_add();
        logic [LW-1:0] t;
        fill_basic();
        st_oadd[1] = 1'b1;
        build_model(8, 4, 0, 2);
        do_start(0, 0, 2);
        run_stream(0, 200);
        n_tests++;
        if (timed_out || got_l.size() != 6 || done_idx != 5) begin
            n_fail++;
            $display("FAIL oadd_count: got %0d outputs done_at=%0d, want 6/5", got_l.size(), done_idx);
        end
        for (int i = 0; i < exp_l.size(); i++) begin
            n_tests++;
            if (i >= got_l.size() || got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                n_fail++;
                $display("FAIL oadd_out%0d: got %h/%h want %h/%h", i,
                         (i < got_l.size()) ? got_l[i] : 'x, (i < got_r.size()) ? got_r[i] : 'x, exp_l[i], exp_r[i]);
            end
        end
        if (got_l.size() > 1) begin
            t = got_r[1];
            n_tests++;
            if (got_l[1][WW-1:0] !== 32'h33 || t[WW-1:0] !== 32'h22) begin
                n_fail++;
                $display("FAIL oadd_lane0_out2: got %h/%h want 33/22", got_l[1][WW-1:0], t[WW-1:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        fill_basic();
        build_model(8, 4, 0, 2);
        do_start(0, 0, 2);
        run_stream(1, 200);
        n_tests++;
        if (hold_viol != 0 || timed_out) begin
            n_fail++;
            $display("FAIL bp_hold: violations=%0d timeout=%0d want 0/0", hold_viol, timed_out);
        end
        n_tests++;
        if (got_l.size() != exp_l.size() || done_cycles != 1 || done_idx != 6) begin
            n_fail++;
            $display("FAIL bp_count: outputs=%0d done=%0d/%0d want %0d 1/6",
                     got_l.size(), done_cycles, done_idx, exp_l.size());
        end
        for (int i = 0; i < exp_l.size(); i++) begin
            n_tests++;
            if (i >= got_l.size() || got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                n_fail++;
                $display("FAIL bp_out%0d: got %h/%h want %h/%h", i,
                         (i < got_l.size()) ? got_l[i] : 'x, (i < got_r.size()) ? got_r[i] : 'x, exp_l[i], exp_r[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [LW-1:0] tl, tr;
        st_len = 24;
        for (int i = 0; i < 64; i++) begin
            st_word[i] = (i < 10) ? WW'(i + 1) : $urandom;
            st_oadd[i] = 1'b0;
        end
        build_model(4, 10, 2, 0);
        do_start(1, 2, 0);
        run_stream(0, 300);
        n_tests++;
        if (timed_out || got_l.size() != 13 || done_idx != 12 || got_acc != exp_acc) begin
            n_fail++;
            $display("FAIL wrap_count: outputs=%0d done_at=%0d acc=%0d want 13/12/%0d",
                     got_l.size(), done_idx, got_acc, exp_acc);
        end
        for (int i = 0; i < exp_l.size(); i++) begin
            n_tests++;
            if (i >= got_l.size() || got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                n_fail++;
                $display("FAIL wrap_out%0d: got %h/%h want %h/%h", i,
                         (i < got_l.size()) ? got_l[i] : 'x, (i < got_r.size()) ? got_r[i] : 'x, exp_l[i], exp_r[i]);
            end
        end
        if (got_l.size() > 8) begin
            tl = got_l[8];
            tr = got_r[8];
            n_tests++;
            if (tl[WW-1:0] !== 32'd7 || tr[WW-1:0] !== 32'd6) begin
                n_fail++;
                $display("FAIL wrap_out9: got %0d/%0d want 7/6", tl[WW-1:0], tr[WW-1:0]);
            end
        end
    endtask

    task automatic test_cfg_err();
        fill_basic();
        build_model(8, 4, 9, 1);
        do_start(0, 9, 1);
        n_tests++;
        if (o_cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_err_set: cfg_err=%b want 1", o_cfg_err);
        end
        run_stream(0, 200);
        n_tests++;
        if (timed_out || got_l.size() != exp_l.size() || got_acc != exp_acc || done_cycles != 1) begin
            n_fail++;
            $display("FAIL cfg_count: outputs=%0d acc=%0d done=%0d want %0d/%0d/1",
                     got_l.size(), got_acc, done_cycles, exp_l.size(), exp_acc);
        end
        for (int i = 0; i < exp_l.size(); i++) begin
            n_tests++;
            if (i >= got_l.size() || got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                n_fail++;
                $display("FAIL cfg_out%0d: got %h/%h want %h/%h", i,
                         (i < got_l.size()) ? got_l[i] : 'x, (i < got_r.size()) ? got_r[i] : 'x, exp_l[i], exp_r[i]);
            end
        end
        do_start(0, 0, 2);
        n_tests++;
        if (o_cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_err_clear: cfg_err=%b want 0", o_cfg_err);
        end
    endtask

    task automatic test_random();
        int s, depth, wc, off0, off1;
        for (int it = 0; it < 8; it++) begin
            s = $urandom_range(0, 1);
            depth = (s == 1) ? 4 : 8;
            wc = (s == 1) ? 10 : 4;
            off0 = $urandom_range(0, 15);
            off1 = $urandom_range(0, 15);
            st_len = 64;
            for (int i = 0; i < 64; i++) begin
                st_word[i] = $urandom;
                st_oadd[i] = (i < 20) && ($urandom_range(0, 3) == 0);
            end
            build_model(depth, wc, off0, off1);
            do_start(s, off0, off1);
            n_tests++;
            if (o_cfg_err !== exp_err) begin
                n_fail++;
                $display("FAIL rnd%0d_cfg_err: got %b want %b (offs %0d,%0d)", it, o_cfg_err, exp_err, off0, off1);
            end
            run_stream(2, 800);
            n_tests++;
            if (timed_out || hold_viol != 0 || got_l.size() != exp_l.size() || got_acc != exp_acc
                || done_cycles != 1 || done_idx != exp_l.size() - 1) begin
                n_fail++;
                $display("FAIL rnd%0d_flow: outs=%0d/%0d acc=%0d/%0d done=%0d at %0d hold=%0d to=%0d",
                         it, got_l.size(), exp_l.size(), got_acc, exp_acc, done_cycles, done_idx, hold_viol, timed_out);
            end
            for (int i = 0; i < exp_l.size(); i++) begin
                n_tests++;
                if (i >= got_l.size() || got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d_out%0d: got %h/%h want %h/%h", it, i,
                             (i < got_l.size()) ? got_l[i] : 'x, (i < got_r.size()) ? got_r[i] : 'x, exp_l[i], exp_r[i]);
                end
            end
        end
    endtask

    task automatic test_reset_restart();
        fill_basic();
        do_start(0, 9, 2);
        run_stream(0, 4);
        n_tests++;
        if (o_valid !== 1'b1 || o_cfg_err !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: out_valid=%b cfg_err=%b want 1/1", o_valid, o_cfg_err);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_in_ready, o_valid, o_done, o_cfg_err} !== 4'b0000 || o_left !== '0 || o_right !== '0) begin
            n_fail++;
            $display("FAIL rst_async: rdy/val/done/err=%b left=%h right=%h want all zero",
                     {o_in_ready, o_valid, o_done, o_cfg_err}, o_left, o_right);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        build_model(8, 4, 0, 2);
        do_start(0, 0, 2);
        run_stream(0, 200);
        n_tests++;
        if (timed_out || got_l.size() != 7 || done_idx != 6) begin
            n_fail++;
            $display("FAIL rst_restart_count: outputs=%0d done_at=%0d want 7/6", got_l.size(), done_idx);
        end
        for (int i = 0; i < exp_l.size(); i++) begin
            n_tests++;
            if (i >= got_l.size() || got_l[i] !== exp_l[i] || got_r[i] !== exp_r[i]) begin
                n_fail++;
                $display("FAIL rst_out%0d: got %h/%h want %h/%h", i,
                         (i < got_l.size()) ? got_l[i] : 'x, (i < got_r.size()) ? got_r[i] : 'x, exp_l[i], exp_r[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        test_reset();
        test_basic();
        test_only_add();
        test_backpressure();
        test_wrap();
        test_cfg_err();
        test_random();
        test_reset_restart();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
